// File: rtl/button_method_caller.sv
// Push-button initiator for a Bluespec action method: synchronise, debounce, queue presses
// and issue one EN_inc strobe per accepted press whenever the callee reports RDY_inc.
module button_method_caller #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned MAX_PENDING     = 3,
  parameter int unsigned CALLS_W         = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               btn_i,
  input  logic               RDY_inc,
  output logic               EN_inc,
  output logic [3:0]         pending,
  output logic               dropped,
  output logic [CALLS_W-1:0] call_count
);

  localparam int unsigned        DcntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DcntW-1:0]   DcntMax = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]         PendMax = 4'(MAX_PENDING);

  logic               s1_q, s2_q;
  logic               db_q, db_d;
  logic [DcntW-1:0]   dcnt_q, dcnt_d;
  logic [3:0]         pend_q, pend_d;
  logic               drop_q, drop_d;
  logic [CALLS_W-1:0] calls_q, calls_d;
  logic               press;
  logic               issue;

  // Two-flop synchroniser; only s2_q is allowed to reach the debouncer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // A new level must be seen for DEBOUNCE_CYCLES consecutive cycles before it is accepted;
  // any return to the accepted level restarts the count.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    press  = 1'b0;
    if (s2_q != db_q) begin
      if (dcnt_q == DcntMax) begin
        db_d  = s2_q;
        press = s2_q;
      end else begin
        dcnt_d = dcnt_q + DcntW'(1'b1);
      end
    end
  end

  assign issue = (pend_q != 4'd0) && RDY_inc;

  always_comb begin
    pend_d  = pend_q;
    drop_d  = drop_q;
    calls_d = calls_q;
    case ({press, issue})
      2'b10: begin
        if (pend_q < PendMax) begin
          pend_d = pend_q + 4'd1;
        end else begin
          drop_d = 1'b1;
        end
      end
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
    if (issue) begin
      calls_d = calls_q + CALLS_W'(1'b1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_q    <= 1'b0;
      dcnt_q  <= '0;
      pend_q  <= 4'd0;
      drop_q  <= 1'b0;
      calls_q <= '0;
    end else begin
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      calls_q <= calls_d;
    end
  end

  assign EN_inc     = issue;
  assign pending    = pend_q;
  assign dropped    = drop_q;
  assign call_count = calls_q;

endmodule

// File: tb/tb_button_method_caller.sv
// Scoreboarded bench for button_method_caller with a 4-cycle debounce and 3-deep pending queue.
module tb_button_method_caller;

  localparam int unsigned N  = 4;
  localparam int unsigned MP = 3;
  localparam int unsigned CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          btn_i;
  logic          RDY_inc;
  logic          EN_inc;
  logic [3:0]    pending;
  logic          dropped;
  logic [CW-1:0] call_count;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            en_seen  = 0;
  logic [CW-1:0] exp_calls = '0;
  logic [CW-1:0] exp_q[$];

  button_method_caller #(
    .DEBOUNCE_CYCLES(N),
    .MAX_PENDING    (MP),
    .CALLS_W        (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .btn_i     (btn_i),
    .RDY_inc   (RDY_inc),
    .EN_inc    (EN_inc),
    .pending   (pending),
    .dropped   (dropped),
    .call_count(call_count)
  );

  always #5 CLK = ~CLK;

  // Each observed call pops the call_count value the model expects at issue time.
  always @(negedge CLK) begin
    if (!RST && EN_inc) begin
      logic [CW-1:0] e;
      en_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_call: EN_inc=1 call_count=%0d, required no call", call_count);
      end else begin
        e = exp_q.pop_front();
        if (call_count !== e) begin
          n_fail++;
          $display("FAIL call_value: call_count=%0d at issue, required %0d", call_count, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    btn_i   = 1'b0;
    RDY_inc = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    exp_calls = '0;
    en_seen   = 0;
  endtask

  task automatic press(input int hold, input int rel);
    @(posedge CLK);
    #1 btn_i = 1'b1;
    repeat (hold) @(posedge CLK);
    #1 btn_i = 1'b0;
    repeat (rel) @(posedge CLK);
    #1;
  endtask

  task automatic run_calls(input int n);
    RDY_inc = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_calls);
      exp_calls++;
      press(7, 7);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; btn_i = 1'b0; RDY_inc = 1'b0;
    #2;
    n_checks++;
    if ({EN_inc, pending, dropped, call_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: EN=%b pending=%0d dropped=%b calls=%0d, required all 0",
               EN_inc, pending, dropped, call_count);
    end
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    RDY_inc = 1'b1;
    exp_q.push_back(exp_calls);
    exp_calls++;
    btn_i = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      #1;
      if (e == 4) begin
        n_checks++;
        if (pending !== 4'd0 || EN_inc !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_edge4: pending=%0d EN=%b, required 0 0", pending, EN_inc);
        end
      end
      if (e == 5) begin
        n_checks++;
        if (pending !== 4'd1 || EN_inc !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_edge5: pending=%0d EN=%b, required 1 1", pending, EN_inc);
        end
      end
    end
    btn_i = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    #1;
    n_checks++;
    if (en_seen !== 1 || call_count !== 8'd1 || pending !== 4'd0) begin
      n_fail++;
      $display("FAIL clean_total: calls_seen=%0d call_count=%0d pending=%0d, required 1 1 0",
               en_seen, call_count, pending);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    do_reset();
    RDY_inc = 1'b1;
    exp_q.push_back(exp_calls);
    exp_calls++;
    pat = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      btn_i = pat[i];
      @(posedge CLK);
      #1;
    end
    repeat (12) @(posedge CLK);
    #1 btn_i = 1'b0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    #1;
    n_checks++;
    if (en_seen !== 1 || call_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bounce: calls_seen=%0d call_count=%0d, required 1 1", en_seen, call_count);
    end
  endtask

  task automatic test_glitch();
    bit seen_pend;
    do_reset();
    RDY_inc   = 1'b1;
    seen_pend = 1'b0;
    btn_i     = 1'b1;
    repeat (3) @(posedge CLK);
    #1 btn_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      #1;
      if (pending !== 4'd0) seen_pend = 1'b1;
    end
    n_checks++;
    if (seen_pend || en_seen !== 0 || call_count !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch: pending_seen=%b calls_seen=%0d call_count=%0d, required 0 0 0",
               seen_pend, en_seen, call_count);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] ep;
    do_reset();
    RDY_inc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(7, 7);
      @(negedge CLK);
      #1;
      ep = (i < 3) ? 4'(i + 1) : 4'(MP);
      n_checks++;
      if (pending !== ep || dropped !== (i >= 3)) begin
        n_fail++;
        $display("FAIL overflow_press%0d: pending=%0d dropped=%b, required %0d %b",
                 i, pending, dropped, ep, (i >= 3));
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_calls);
      exp_calls++;
    end
    @(posedge CLK);
    #1 RDY_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      ep = (i < 3) ? 4'(3 - i) : 4'd0;
      n_checks++;
      if (pending !== ep || EN_inc !== (i < 3)) begin
        n_fail++;
        $display("FAIL drain%0d: pending=%0d EN=%b, required %0d %b",
                 i, pending, EN_inc, ep, (i < 3));
      end
      @(posedge CLK);
    end
    #1;
    n_checks++;
    if (call_count !== 8'd3 || dropped !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_end: call_count=%0d dropped=%b left=%0d, required 3 1 0",
               call_count, dropped, exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    RDY_inc = 1'b0;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    exp_calls = 8'd2;
    press(8, 8);
    @(posedge CLK);
    #1 btn_i = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RDY_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if (i < 2) begin
        if (EN_inc !== 1'b1 || pending !== 4'd1 || call_count !== 8'(i)) begin
          n_fail++;
          $display("FAIL simul%0d: EN=%b pending=%0d calls=%0d, required 1 1 %0d",
                   i, EN_inc, pending, call_count, i);
        end
      end else begin
        if (EN_inc !== 1'b0 || pending !== 4'd0 || call_count !== 8'd2) begin
          n_fail++;
          $display("FAIL simul_drained: EN=%b pending=%0d calls=%0d, required 0 0 2",
                   EN_inc, pending, call_count);
        end
      end
    end
    btn_i = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    run_calls(255);
    @(negedge CLK);
    #1;
    n_checks++;
    if (call_count !== 8'd255) begin
      n_fail++;
      $display("FAIL preload_255: call_count=%0d, required 255", call_count);
    end
    RDY_inc = 1'b0;
    press(7, 7);
    press(7, 7);
    @(negedge CLK);
    #1;
    n_checks++;
    if (pending !== 4'd2) begin
      n_fail++;
      $display("FAIL preload_pending: pending=%0d, required 2", pending);
    end
    btn_i = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if ({EN_inc, pending, dropped, call_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: EN=%b pending=%0d dropped=%b calls=%0d, required all 0",
               EN_inc, pending, dropped, call_count);
    end
    btn_i = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    exp_calls = '0;
    en_seen   = 0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    #1;
    n_checks++;
    if (pending !== 4'd0 || en_seen !== 0) begin
      n_fail++;
      $display("FAIL post_reset: pending=%0d calls_seen=%0d, required 0 0", pending, en_seen);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_calls(255);
    @(negedge CLK);
    #1;
    n_checks++;
    if (call_count !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_pre: call_count=%0d, required 255", call_count);
    end
    run_calls(1);
    @(negedge CLK);
    #1;
    n_checks++;
    if (call_count !== 8'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap: call_count=%0d left=%0d, required 0 0", call_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d calls outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_method_caller.md
# button_method_caller

Initiator side of a Bluespec-style action-method handshake for the iCEstick designs. It synchronises and debounces a raw push-button, turns each debounced press into exactly one `EN_*` pulse, and holds presses as pending while the callee's `RDY_*` is low. It sits in a board top level between a pad input and a Bluespec module's `EN_inc`/`RDY_inc` method pins, with a pending queue, a drop flag and a call counter.

## Interface
- `DEBOUNCE_CYCLES`, default 12000: consecutive synchronised cycles an input level must hold before it is accepted (1 ms at 12 MHz); legal range ≥ 2.
- `MAX_PENDING`, default 3: maximum queued, unissued presses; legal range 1..15.
- `CALLS_W`, default 8: width of `call_count`.

Ports:
- `CLK`  in  1  sole clock; all state on its rising edge.
- `RST`  in  1  reset, asynchronous and active-high; one clock, `CLK`.
- `btn_i`  in  1  raw button level, asynchronous to `CLK`, high = pressed.
- `RDY_inc`  in  1  callee ready for the action method.
- `EN_inc`  out  1  method call strobe; one call per cycle in which it is high.
- `pending`  out  4  presses accepted but not yet issued.
- `dropped`  out  1  sticky flag: at least one press was lost to overflow.
- `call_count`  out  `CALLS_W`  total calls issued, wraps modulo 2^`CALLS_W`.

## Operation
- Synchroniser: two flops, `s1 <= btn_i`, `s2 <= s1`. Only `s2` is used downstream.
- Debouncer: holds the accepted level `db` and a counter `dcnt` of width clog2(`DEBOUNCE_CYCLES`).
  - `s2 == db`: clear `dcnt`.
  - `s2 != db` and `dcnt < DEBOUNCE_CYCLES-1`: increment `dcnt`.
  - `s2 != db` and `dcnt == DEBOUNCE_CYCLES-1`: set `db <= s2`, clear `dcnt`.
  - Any return of `s2` to `db` restarts the count.
- Press event: `press` is combinational, high in the cycle where the debouncer sets `db` from 0 to 1. A 1→0 transition produces no event.
- Issue: `EN_inc = (pending != 0) && RDY_inc`, combinational. `EN_inc` never rises while `RDY_inc` is low.
- Pending update per edge:
  - `press` and `EN_inc` together: unchanged.
  - `press` only, `pending < MAX_PENDING`: +1.
  - `press` only, `pending == MAX_PENDING`: unchanged, set `dropped`.
  - `EN_inc` only: −1.
- `call_count` increments on every edge with `EN_inc` high and wraps from all-ones to 0.
- `dropped` is cleared only by `RST`.
- Reset values: `s1`, `s2`, `db`, `dcnt`, `pending`, `call_count` and `dropped` are all 0, so `EN_inc` is 0.
- Holding `btn_i` high through reset deassertion counts as one press once debounced.

## Timing
- `btn_i` first sampled high at edge k and held: `s2 = 1` after edge k+1. `dcnt` counts 0..N-1 over edges k+2..k+N+1. `db` and `pending` go to 1 at edge k+N+1, where N = `DEBOUNCE_CYCLES`.
- `EN_inc` is high in the cycle after that edge if `RDY_inc` is high. Press-to-call latency is therefore N+2 edges after first sampling.
- A high pulse on `s2` shorter than N cycles generates no event.
- Back-to-back calls are allowed: with `RDY_inc` held high, `pending` = P drains in P consecutive cycles of `EN_inc` high.
- `RST` assertion clears all state immediately, without waiting for a clock edge, including mid-debounce and with calls pending. Pending presses are discarded.
- Release of `RST` is synchronous to `CLK` at board level, so no internal reset synchroniser is required.

## Test plan
- Clean press (N=4, `RDY_inc`=1):
  - Stimulus: `btn_i` high from edge 0, held for 20 cycles.
  - Required: `pending`=1 after edge 5; `EN_inc` high for exactly one cycle; `call_count`=1; no event on release.
- Bounce (N=4):
  - Stimulus: `btn_i` toggles 1,0,1,0 on successive cycles, then holds 1.
  - Required: exactly one call; `call_count`=1.
- Glitch (N=4):
  - Stimulus: `btn_i` high for 3 cycles, then low.
  - Required: `db`, `pending`, `EN_inc` and `call_count` stay 0.
- Backpressure and overflow (N=4, `MAX_PENDING`=3, `RDY_inc`=0):
  - Stimulus: 5 separate debounced presses, then `RDY_inc`=1.
  - Required: `pending` saturates at 3; `dropped`=1; then 3 consecutive `EN_inc` cycles; `pending`=0; `call_count`=3; `dropped` still 1.
- Simultaneous press and issue:
  - Stimulus: `pending`=1 and `RDY_inc`=1 in the same cycle as `press`.
  - Required: `EN_inc`=1, `pending` stays 1, then drains next cycle; `call_count`=2.
- Reset:
  - Stimulus: assert `RST` mid-debounce with `pending`=2 and `call_count`=255 (`CALLS_W`=8).
  - Required: all outputs 0 immediately, without a clock edge.
  - Separately, a wrap check: `call_count`=255 followed by one call gives 0.
